// File: rtl/hight_axi_lite_ctrl.sv
// AXI4-Lite register front-end for a HIGHT block cipher core: key/data/result registers, START/DONE handshake.
// Optional level interrupt (DONE & CTRL.IE) is built when the macro HIGHT_IRQ_EN is defined.
module hight_axi_lite_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            core_start,
  output logic                            core_dec,
  output logic [127:0]                    core_key,
  output logic [63:0]                     core_din,
  input  logic [63:0]                     core_dout,
  input  logic                            core_done
`ifdef HIGHT_IRQ_EN
  ,
  output logic                            irq
`endif
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_awready, r_bvalid, r_arready, r_rvalid;
  logic [31:0] r_rdata, w_rd_data;
  logic        r_start, r_dec, r_done;
  logic [31:0] r_key0, r_key1, r_key2, r_key3, r_din0, r_din1, r_dout0, r_dout1;
  logic        w_wr_acc, w_rd_acc, w_idle, w_start_acc, w_core_fin, w_done_w1c, w_ie;
  logic [3:0]  w_wr_idx, w_rd_idx;
  logic        w_unused;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Ready is raised one cycle after both valids are seen, so the handshake cycle is the acceptance cycle.
  assign w_wr_acc    = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_acc    = r_arready & S_AXI_ARVALID;
  assign w_wr_idx    = S_AXI_AWADDR[5:2];
  assign w_rd_idx    = S_AXI_ARADDR[5:2];
  assign w_idle      = (r_state == ST_IDLE);
  assign w_start_acc = w_wr_acc & w_idle & (w_wr_idx == 4'd0) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
  assign w_core_fin  = (r_state == ST_RUN) & core_done;
  assign w_done_w1c  = w_wr_acc & (w_wr_idx == 4'd1) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
  assign w_unused    = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign core_start    = r_start;
  assign core_dec      = r_dec;
  assign core_key      = {r_key3, r_key2, r_key1, r_key0};
  assign core_din      = {r_din1, r_din0};

  // FSM state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_acc) w_state_nxt = ST_RUN;
        else             w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (core_done) w_state_nxt = ST_IDLE;
        else           w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // AXI handshake and response channels
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_awready <= ~r_awready & S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid;
      r_arready <= ~r_arready & S_AXI_ARVALID & ~r_rvalid;
      if (w_wr_acc)          r_bvalid <= 1'b1;
      else if (S_AXI_BREADY) r_bvalid <= 1'b0;
      else                   r_bvalid <= r_bvalid;
      if (w_rd_acc) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= r_rvalid;
      end
    end
  end

  // Read data mux
  always_comb begin
    w_rd_data = 32'd0;
    case (w_rd_idx)
      4'd0:    w_rd_data = {29'd0, w_ie, r_dec, 1'b0};
      4'd1:    w_rd_data = {30'd0, r_done, ~w_idle};
      4'd2:    w_rd_data = r_key0;
      4'd3:    w_rd_data = r_key1;
      4'd4:    w_rd_data = r_key2;
      4'd5:    w_rd_data = r_key3;
      4'd6:    w_rd_data = r_din0;
      4'd7:    w_rd_data = r_din1;
      4'd8:    w_rd_data = r_dout0;
      4'd9:    w_rd_data = r_dout1;
      default: w_rd_data = 32'd0;
    endcase
  end

  // Control, operand and result registers; operands are frozen while the core runs
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_start <= 1'b0;
      r_dec   <= 1'b0;
      r_done  <= 1'b0;
      r_key0  <= 32'd0;
      r_key1  <= 32'd0;
      r_key2  <= 32'd0;
      r_key3  <= 32'd0;
      r_din0  <= 32'd0;
      r_din1  <= 32'd0;
      r_dout0 <= 32'd0;
      r_dout1 <= 32'd0;
    end else begin
      r_start <= w_start_acc;
      if (w_wr_acc && w_idle) begin
        case (w_wr_idx)
          4'd0:    if (S_AXI_WSTRB[0]) r_dec <= S_AXI_WDATA[1];
          4'd2:    r_key0 <= apply_strb(r_key0, S_AXI_WDATA, S_AXI_WSTRB);
          4'd3:    r_key1 <= apply_strb(r_key1, S_AXI_WDATA, S_AXI_WSTRB);
          4'd4:    r_key2 <= apply_strb(r_key2, S_AXI_WDATA, S_AXI_WSTRB);
          4'd5:    r_key3 <= apply_strb(r_key3, S_AXI_WDATA, S_AXI_WSTRB);
          4'd6:    r_din0 <= apply_strb(r_din0, S_AXI_WDATA, S_AXI_WSTRB);
          4'd7:    r_din1 <= apply_strb(r_din1, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end
      if (w_core_fin) begin
        r_dout0 <= core_dout[31:0];
        r_dout1 <= core_dout[63:32];
      end
      // A completion outranks a same-cycle W1C; START only happens in IDLE so it never meets a completion.
      if (w_core_fin)                    r_done <= 1'b1;
      else if (w_start_acc || w_done_w1c) r_done <= 1'b0;
      else                               r_done <= r_done;
    end
  end

`ifdef HIGHT_IRQ_EN
  logic r_ie, r_irq;
  assign w_ie = r_ie;
  assign irq  = r_irq;

  // Interrupt enable (writable in any state) and registered interrupt level
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr_acc && (w_wr_idx == 4'd0) && S_AXI_WSTRB[0]) r_ie <= S_AXI_WDATA[2];
      else                                                  r_ie <= r_ie;
      r_irq <= r_done & r_ie;
    end
  end
`else
  assign w_ie = 1'b0;
`endif

endmodule

// File: doc/hight_axi_lite_ctrl.md
HIGHT_AXI_LITE_CTRL -- requirements
Module: hight_axi_lite_ctrl

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6: byte address width.
REQ-003 SHALL have ports S_AXI_ACLK in 1 (single clock) and S_AXI_ARESETN in 1; reset is asynchronous and active-low.
REQ-004 SHALL have write ports S_AXI_AWADDR in 6, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1, S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1, S_AXI_BRESP out 2, S_AXI_BVALID out 1 and S_AXI_BREADY in 1.
REQ-005 SHALL have read ports S_AXI_ARADDR in 6, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1 and S_AXI_RREADY in 1.
REQ-006 SHALL have core ports core_start out 1 (one-cycle pulse), core_dec out 1 (1 = decrypt), core_key out 128 (KEY3 is MSW), core_din out 64 (DIN1 is MSW), core_dout in 64 and core_done in 1 (one-cycle pulse, dout valid).
REQ-007 SHALL, when HIGHT_IRQ_EN is defined, have irq out 1 (level, active-high).

Function
REQ-008 SHALL decode word index = AWADDR/ARADDR[5:2]: 0 CTRL (bit0 START, W1 self-clear, reads 0; bit1 DEC; bit2 IE), 1 STATUS (bit0 BUSY RO; bit1 DONE sticky, write 1 clears), 2-5 KEY0-KEY3 RW, 6-7 DIN0-DIN1 RW, 8-9 DOUT0-DOUT1 RO.
REQ-009 SHALL accept a write only in a cycle where AWVALID=1, WVALID=1 and BVALID=0, pulsing AWREADY and WREADY high together for exactly that cycle.
REQ-010 SHALL assert BVALID on the cycle after write acceptance, hold it until BREADY=1, and drive BRESP=00 on every write.
REQ-011 SHALL apply WSTRB per byte lane to RW registers; RO and unmapped writes are ignored.
REQ-012 SHALL accept a read when ARVALID=1 and RVALID=0, pulsing ARREADY for that cycle, with RVALID and RDATA registered the next cycle and held stable until RREADY=1; RRESP=00; unmapped words read 0.
REQ-013 SHALL implement FSM IDLE/RUN: IDLE->RUN on an accepted CTRL write with WDATA[0]=1 and WSTRB[0]=1; RUN->IDLE on core_done=1.
REQ-014 SHALL assert core_start for exactly one cycle, the cycle after START acceptance, while BUSY=1 from that same cycle.
REQ-015 SHALL, on core_done in RUN, capture core_dout into DOUT1:DOUT0 and set DONE and clear BUSY on the following cycle.
REQ-016 SHALL, in RUN, ignore writes to CTRL.START, CTRL.DEC, KEY and DIN, still responding BRESP=00.
REQ-017 SHALL let a DONE set win over a simultaneous DONE W1C in the same cycle.
REQ-018 SHALL clear DONE on acceptance of a new START.
REQ-019 SHALL ignore core_done received in IDLE: no DOUT update and no DONE set.
REQ-020 SHALL drive core_key, core_din and core_dec continuously from the registers.

Reset
REQ-021 SHALL, on S_AXI_ARESETN=0, asynchronously clear all registers, FSM to IDLE, and AWREADY, WREADY, BVALID, ARREADY, RVALID, core_start and irq to 0; BRESP, RRESP and RDATA to 0.
REQ-022 SHALL abort an in-flight operation on reset, leaving no pending core_start and no AXI response after release.

Configuration
REQ-023 SHALL, with HIGHT_IRQ_EN defined, provide port irq = DONE & CTRL.IE, registered, with CTRL bit2 RW.
REQ-024 SHALL, without HIGHT_IRQ_EN, omit port irq, make CTRL bit2 read 0 and ignore writes to it.

Verification
REQ-025 SHALL cover: write KEY3..0 = 00112233/44556677/8899AABB/CCDDEEFF, DIN=0, CTRL=1, core model returns 00F418AE_D94F03F2 -> DOUT1=00F418AE, DOUT0=D94F03F2, STATUS=2.
REQ-026 SHALL cover: write KEY0=FFFFFFFF with WSTRB=0101 after reset -> KEY0 reads 00FF00FF.
REQ-027 SHALL cover: CTRL=1 while BUSY -> exactly one core_start pulse, BRESP=00, STATUS reads 1.
REQ-028 SHALL cover: core_done and STATUS write 2 in the same cycle -> STATUS reads 2.
REQ-029 SHALL cover: hold BREADY=0 for 5 cycles after a write -> BVALID held, and a second AW/W pair is not accepted until BREADY=1.
REQ-030 SHALL cover: assert reset during RUN, release, then read STATUS -> 0, with core_start never asserted after release; with HIGHT_IRQ_EN defined, CTRL=6 then a completed operation -> irq=1, and STATUS write 2 -> irq=0.
